itag_array_nway: RTL and testbench
==================================

// Module: itag_array_nway
// PURPOSE
// - Parametrised N-way instruction-cache tag store with valid bits, a hardware flush
//   sequencer and a round-robin replacement-way generator.
// - Sits between the fetch stage1/stage2 pipeline and the icache line-fill logic.
// - Stage1 reads all ways' tags for the line index; stage2 compares against the stage2 tag.
// - The flush sequencer invalidates the whole array after reset and on a fence.i request.
// PARAMETERS
// - WAYS         2   number of ways (1..8); one tag bank per way
// - LINES        64  sets per way (power of 2); LINE_W = $clog2(LINES)
// - TAG_W        20  stored tag width
// - SUB_LINE_W   2   word-offset bits inside a line
//   Line index = addr[2+SUB_LINE_W +: LINE_W].
//   Tag = addr[2+SUB_LINE_W+LINE_W +: TAG_W].
// PORTS
// - clk           in   1     clock, all logic on rising edge
// - rst_n         in   1     synchronous active-low reset
// - stage1_addr   in   32    lookup address, read issued when stage1_adv=1
// - stage1_adv    in   1     stage1 advancing: read all banks at stage1_addr index
// - stage2_addr   in   32    address in stage2; compare tag and update index/tag source
// - update        in   1     line fill complete: write tag for stage2_addr
// - update_way    in   WAYS  one-hot way written on update
// - flush_req     in   1     pulse: invalidate all lines
// - flush_busy    out  1     flush sequencer active
// - tag_hit       out  1     OR of tag_hit_way
// - tag_hit_way   out  WAYS  one-hot way whose valid tag matches stage2 tag
// - replace_way   out  WAYS  one-hot victim suggestion for the next fill
// - parity_err    out  1     only present with ITAG_PARITY_EN
// BEHAVIOUR
// - Reset values while rst_n=0: flush_busy=0, tag_hit=0, tag_hit_way=0,
//   replace_way=WAYS'(1), parity_err=0, hit_allowed=0.
// - Reset clears no RAM contents; the flush sequencer does it.
// - FSM states:
//   - FLUSH: entered on the first cycle after rst_n rises, and from IDLE on flush_req.
//     Counter idx starts at 0. Each cycle all ways are written valid=0 at idx, then idx++.
//     At idx==LINES-1 the FSM goes to IDLE. Duration is exactly LINES cycles, with
//     flush_busy=1 throughout.
//   - IDLE: flush_busy=0.
// - Entry: {valid, tag}. Lookup latency is 1 cycle.
//   - hit_allowed <= stage1_adv & ~flush_busy.
//   - tag_hit_way[i] = hit_allowed & valid_i & (tag_i == stage2 tag).
// - Banks read only when stage1_adv=1; otherwise the read data holds.
// - At most one way may hit. A multi-way hit is an assertion failure, not handled.
// - update (IDLE only): way(s) in update_way write {1, stage2 tag} at the stage2 index.
//   update_way must be one-hot.
// - Replacement: replace_way rotates left by 1 (wrapping WAYS-1 -> 0) on each accepted
//   update. With WAYS=1 it is constant 1.
// - Simultaneous events:
//   - flush_req during FLUSH: idx restarts at 0.
//   - update during FLUSH, or in the same cycle as flush_req: update ignored, flush wins,
//     replace_way unchanged.
//   - update and stage1 read to the same index in the same cycle: the read returns
//     old contents (read-first, no bypass).
//   - stage1_adv during FLUSH: the read is issued, but hit_allowed=0 next cycle.
// - Reset mid-flush aborts the FSM; a new full flush starts after rst_n rises.
// CONFIGURATION
// - ITAG_PARITY_EN defined: each entry stores an extra even-parity bit over {valid, tag}.
//   - On a lookup with hit_allowed=1, any way with a parity mismatch forces that way's
//     tag_hit_way bit to 0, and parity_err=1 for that cycle. The fetch unit treats it
//     as a miss and refills.
//   - Flush writes parity-consistent zero entries.
// - ITAG_PARITY_EN undefined: no parity bit stored; parity_err port absent;
//   entry width is TAG_W+1.
// TESTING
// - Flush: release rst_n -> flush_busy=1 for exactly 64 cycles, then 0.
//   Lookup of 0x0000_1000 during or after -> tag_hit=0.
// - Fill and hit: update with update_way=2'b10, stage2_addr=0x8000_0040; then stage1/stage2
//   at 0x8000_0044 -> tag_hit_way=2'b10 one cycle after stage1_adv.
//   Address 0x9000_0040 -> miss.
// - Replacement: 3 updates from reset with WAYS=4 -> replace_way 0001->0010->0100->1000.
//   A 4th update wraps it to 0001.
// - Collision: update and flush_req in the same cycle -> update dropped, replace_way
//   unchanged, later lookup misses. A second flush_req at flush cycle 10 -> flush_busy
//   lasts 10+64 cycles.
// - Read-first: stage1_adv and update to the same index and way in the same cycle ->
//   next-cycle compare uses old tag (miss). A repeat lookup hits.
// - With ITAG_PARITY_EN: force-flip one stored tag bit in way 0 at index 1 -> lookup
//   gives tag_hit_way[0]=0, parity_err=1 for 1 cycle.

Source files
------------

// File: rtl/itag_array_nway_if.sv
// Bus between the fetch pipeline / line-fill logic and the N-way instruction tag store.
// parity_err is carried only when ITAG_PARITY_EN is defined.
interface itag_array_nway_if #(
    parameter int WAYS = 2
);
    logic [31:0]     stage1_addr;
    logic            stage1_adv;
    logic [31:0]     stage2_addr;
    logic            update;
    logic [WAYS-1:0] update_way;
    logic            flush_req;
    logic            flush_busy;
    logic            tag_hit;
    logic [WAYS-1:0] tag_hit_way;
    logic [WAYS-1:0] replace_way;
`ifdef ITAG_PARITY_EN
    logic            parity_err;
`endif

    modport master (
        output stage1_addr, stage1_adv, stage2_addr, update, update_way, flush_req,
`ifdef ITAG_PARITY_EN
        input  parity_err,
`endif
        input  flush_busy, tag_hit, tag_hit_way, replace_way
    );

    modport slave (
        input  stage1_addr, stage1_adv, stage2_addr, update, update_way, flush_req,
`ifdef ITAG_PARITY_EN
        output parity_err,
`endif
        output flush_busy, tag_hit, tag_hit_way, replace_way
    );
endinterface

// File: rtl/itag_array_nway.sv
// N-way icache tag store: valid+tag banks, flush sequencer, round-robin victim pointer.
// Optional feature macro: ITAG_PARITY_EN (per-entry even parity over {valid, tag}).
module itag_array_nway #(
    parameter int WAYS       = 2,
    parameter int LINES      = 64,
    parameter int TAG_W      = 20,
    parameter int SUB_LINE_W = 2
) (
    input logic          clk,
    input logic          rst_n,
    itag_array_nway_if.slave bus
);
    localparam int LINE_W = $clog2(LINES);
    localparam int IDX_LO = 2 + SUB_LINE_W;
    localparam int TAG_LO = IDX_LO + LINE_W;
`ifdef ITAG_PARITY_EN
    localparam int ENT_W  = TAG_W + 2;
`else
    localparam int ENT_W  = TAG_W + 1;
`endif

    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_IDLE  = 2'd2;

    logic [1:0]        state;
    logic [LINE_W-1:0] idx;
    logic              hit_allowed;
    logic [WAYS-1:0]   replace_q;

    logic [ENT_W-1:0]  mem  [WAYS][LINES];
    logic [ENT_W-1:0]  rd_q [WAYS];

    logic [LINE_W-1:0] idx1;
    logic [LINE_W-1:0] idx2;
    logic [TAG_W-1:0]  tag2;
    logic              flushing;
    logic              upd_ok;
    logic [ENT_W-1:0]  wr_ent;
    logic [WAYS-1:0]   hit_way;
    logic [WAYS-1:0]   perr;
    logic              unused_addr;

    assign idx1     = bus.stage1_addr[IDX_LO +: LINE_W];
    assign idx2     = bus.stage2_addr[IDX_LO +: LINE_W];
    assign tag2     = bus.stage2_addr[TAG_LO +: TAG_W];
    assign flushing = (state == ST_FLUSH);
    assign upd_ok   = bus.update && (state == ST_IDLE) && !bus.flush_req;
    assign unused_addr = ^{bus.stage1_addr, bus.stage2_addr};

`ifdef ITAG_PARITY_EN
    assign wr_ent = {^{1'b1, tag2}, 1'b1, tag2};
`else
    assign wr_ent = {1'b1, tag2};
`endif

    // ST_RST holds the sequencer off while rst_n is low so a full flush starts on release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_RST;
            idx         <= '0;
            hit_allowed <= 1'b0;
            replace_q   <= WAYS'(1);
        end else begin
            hit_allowed <= bus.stage1_adv && !flushing;
            case (state)
                ST_RST: begin
                    state <= ST_FLUSH;
                    idx   <= '0;
                end
                ST_FLUSH: begin
                    if (bus.flush_req) begin
                        idx <= '0;
                    end else if (idx == LINE_W'(LINES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    if (bus.flush_req) begin
                        state <= ST_FLUSH;
                        idx   <= '0;
                    end
                end
            endcase
            if (upd_ok) begin
                replace_q <= (replace_q << 1) | (replace_q >> (WAYS - 1));
            end
        end
    end

    // Banks carry no reset; read-first because rd_q samples the pre-write contents.
    always_ff @(posedge clk) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (flushing) begin
                mem[w][idx] <= '0;
            end else if (upd_ok && bus.update_way[w]) begin
                mem[w][idx2] <= wr_ent;
            end
            if (bus.stage1_adv) begin
                rd_q[w] <= mem[w][idx1];
            end
        end
    end

    always_comb begin
        hit_way = '0;
        perr    = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
`ifdef ITAG_PARITY_EN
            perr[w] = hit_allowed && (^rd_q[w]);
`endif
            hit_way[w] = hit_allowed && rd_q[w][TAG_W] && (rd_q[w][TAG_W-1:0] == tag2) && !perr[w];
        end
    end

    assign bus.flush_busy  = flushing;
    assign bus.tag_hit_way = hit_way;
    assign bus.tag_hit     = |hit_way;
    assign bus.replace_way = replace_q;
`ifdef ITAG_PARITY_EN
    assign bus.parity_err  = |perr;
`endif

    a_hit_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(hit_way));
    a_upd_onehot: assert property (@(posedge clk) disable iff (!rst_n) bus.update |-> $onehot(bus.update_way));
endmodule

// File: tb/tb_itag_array_nway.sv
// Directed self-checking bench for itag_array_nway (2-way and 4-way instances).
module tb_itag_array_nway;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    itag_array_nway_if #(.WAYS(2)) b2 ();
    itag_array_nway_if #(.WAYS(4)) b4 ();

    itag_array_nway #(.WAYS(2), .LINES(64), .TAG_W(20), .SUB_LINE_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2));
    itag_array_nway #(.WAYS(4), .LINES(64), .TAG_W(20), .SUB_LINE_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] a);
        b2.stage1_addr = a;
        b2.stage2_addr = a;
        b2.stage1_adv  = 1'b1;
        tick();
        b2.stage1_adv  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (b2.flush_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", b2.flush_busy); end
        checks++; if (b2.tag_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b want 0", b2.tag_hit); end
        checks++; if (b2.tag_hit_way !== 2'b00) begin errors++; $display("FAIL reset_hit_way got %b want 00", b2.tag_hit_way); end
        checks++; if (b2.replace_way !== 2'b01) begin errors++; $display("FAIL reset_replace2 got %b want 01", b2.replace_way); end
        checks++; if (b4.replace_way !== 4'b0001) begin errors++; $display("FAIL reset_replace4 got %b want 0001", b4.replace_way); end
    endtask

    task automatic test_flush();
        int cnt;
        rst_n = 1'b1;
        tick();
        cnt = 0;
        while (b2.flush_busy === 1'b1 && cnt < 300) begin
            cnt++;
            if (cnt == 6) begin
                checks++; if (b2.tag_hit !== 1'b0) begin errors++; $display("FAIL flush_lookup_during got %b want 0", b2.tag_hit); end
                b2.stage1_adv = 1'b0;
            end
            if (cnt == 5) begin
                b2.stage1_addr = 32'h0000_1000;
                b2.stage2_addr = 32'h0000_1000;
                b2.stage1_adv  = 1'b1;
            end
            tick();
        end
        checks++; if (cnt != 64) begin errors++; $display("FAIL flush_len got %0d want 64", cnt); end
        checks++; if (b4.flush_busy !== 1'b0) begin errors++; $display("FAIL flush4_done got %b want 0", b4.flush_busy); end
        lookup(32'h0000_1000);
        checks++; if (b2.tag_hit !== 1'b0) begin errors++; $display("FAIL flush_lookup_after got %b want 0", b2.tag_hit); end
    endtask

    task automatic test_fill_hit();
        b2.stage2_addr = 32'h8000_0040;
        b2.update_way  = 2'b10;
        b2.update      = 1'b1;
        tick();
        b2.update      = 1'b0;
        checks++; if (b2.replace_way !== 2'b10) begin errors++; $display("FAIL fill_replace got %b want 10", b2.replace_way); end
        lookup(32'h8000_0044);
        checks++; if (b2.tag_hit_way !== 2'b10) begin errors++; $display("FAIL fill_hit_way got %b want 10", b2.tag_hit_way); end
        checks++; if (b2.tag_hit !== 1'b1) begin errors++; $display("FAIL fill_hit got %b want 1", b2.tag_hit); end
        tick();
        checks++; if (b2.tag_hit !== 1'b0) begin errors++; $display("FAIL hit_one_cycle got %b want 0", b2.tag_hit); end
        lookup(32'h9000_0040);
        checks++; if (b2.tag_hit_way !== 2'b00) begin errors++; $display("FAIL fill_miss got %b want 00", b2.tag_hit_way); end
    endtask

    task automatic test_replacement();
        logic [3:0] exp_rw [4];
        exp_rw = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            b4.stage2_addr = 32'h0000_0400 * (i + 1);
            b4.update_way  = b4.replace_way;
            b4.update      = 1'b1;
            tick();
            b4.update      = 1'b0;
            checks++; if (b4.replace_way !== exp_rw[i]) begin errors++; $display("FAIL replace_step%0d got %b want %b", i, b4.replace_way, exp_rw[i]); end
        end
    endtask

    task automatic test_collision();
        int cnt;
        b2.stage2_addr = 32'h0000_2050;
        b2.update_way  = 2'b01;
        b2.update      = 1'b1;
        b2.flush_req   = 1'b1;
        tick();
        b2.update      = 1'b0;
        b2.flush_req   = 1'b0;
        checks++; if (b2.replace_way !== 2'b10) begin errors++; $display("FAIL coll_replace got %b want 10", b2.replace_way); end
        cnt = 0;
        while (b2.flush_busy === 1'b1 && cnt < 300) begin
            cnt++;
            b2.flush_req = (cnt == 10);
            b2.update    = (cnt == 20);
            tick();
            b2.flush_req = 1'b0;
            b2.update    = 1'b0;
        end
        checks++; if (cnt != 74) begin errors++; $display("FAIL coll_flush_len got %0d want 74", cnt); end
        checks++; if (b2.replace_way !== 2'b10) begin errors++; $display("FAIL coll_upd_in_flush got %b want 10", b2.replace_way); end
        lookup(32'h0000_2050);
        checks++; if (b2.tag_hit !== 1'b0) begin errors++; $display("FAIL coll_dropped got %b want 0", b2.tag_hit); end
        lookup(32'h8000_0044);
        checks++; if (b2.tag_hit !== 1'b0) begin errors++; $display("FAIL coll_flushed got %b want 0", b2.tag_hit); end
    endtask

    task automatic test_read_first();
        b2.stage2_addr = 32'h0000_0040;
        b2.update_way  = 2'b01;
        b2.update      = 1'b1;
        tick();
        b2.stage1_addr = 32'h9000_0040;
        b2.stage2_addr = 32'h9000_0040;
        b2.stage1_adv  = 1'b1;
        b2.update_way  = 2'b01;
        b2.update      = 1'b1;
        tick();
        b2.stage1_adv  = 1'b0;
        b2.update      = 1'b0;
        checks++; if (b2.tag_hit !== 1'b0) begin errors++; $display("FAIL rf_old_data got %b want 0", b2.tag_hit); end
        lookup(32'h9000_0040);
        checks++; if (b2.tag_hit_way !== 2'b01) begin errors++; $display("FAIL rf_repeat got %b want 01", b2.tag_hit_way); end
        lookup(32'h0000_0040);
        checks++; if (b2.tag_hit !== 1'b0) begin errors++; $display("FAIL rf_overwritten got %b want 0", b2.tag_hit); end
    endtask

`ifdef ITAG_PARITY_EN
    task automatic test_parity();
        b2.stage2_addr = 32'h0000_0010;
        b2.update_way  = 2'b01;
        b2.update      = 1'b1;
        tick();
        b2.update      = 1'b0;
        lookup(32'h0000_0010);
        checks++; if (b2.tag_hit_way !== 2'b01) begin errors++; $display("FAIL par_clean_hit got %b want 01", b2.tag_hit_way); end
        dut2.mem[0][1][0] = ~dut2.mem[0][1][0];
        lookup(32'h0000_0010);
        checks++; if (b2.tag_hit_way[0] !== 1'b0) begin errors++; $display("FAIL par_hit_masked got %b want 0", b2.tag_hit_way[0]); end
        checks++; if (b2.parity_err !== 1'b1) begin errors++; $display("FAIL par_err got %b want 1", b2.parity_err); end
        tick();
        checks++; if (b2.parity_err !== 1'b0) begin errors++; $display("FAIL par_err_pulse got %b want 0", b2.parity_err); end
    endtask
`endif

    initial begin
        b2.stage1_addr = '0; b2.stage1_adv = 1'b0; b2.stage2_addr = '0;
        b2.update = 1'b0; b2.update_way = 2'b01; b2.flush_req = 1'b0;
        b4.stage1_addr = '0; b4.stage1_adv = 1'b0; b4.stage2_addr = '0;
        b4.update = 1'b0; b4.update_way = 4'b0001; b4.flush_req = 1'b0;
        test_reset();
        test_flush();
        test_fill_hit();
        test_replacement();
        test_collision();
        test_read_first();
`ifdef ITAG_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
